// File: rtl/fc_operand_loader.sv
// Double-buffered operand loader for a fully connected layer: a beat stream fills a
// working bank (weights row-major then features), and a whole-bank copy commits it to the shadow outputs.
module fc_operand_loader #(
    parameter int BITWIDTH = 32,
    parameter int N_IN     = 10,
    parameter int N_OUT    = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [BITWIDTH-1:0]                    in_data,
    input  logic                                          in_last,
    input  logic                                          in_feat_only,
    output logic signed [N_IN-1:0][BITWIDTH-1:0]          featuremap,
    output logic signed [N_OUT-1:0][N_IN-1:0][BITWIDTH-1:0] connect_matrix,
    output logic                                          out_valid,
    input  logic                                          out_ack,
    output logic                                          frame_err
);

    localparam int NW = N_OUT * N_IN;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_F, HOLD} state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic                             full_q, full_d;
    logic                             wl_q, wl_d;
    logic [NW-1:0][BITWIDTH-1:0]      wt_q, wt_d;
    logic [N_IN-1:0][BITWIDTH-1:0]    ft_q, ft_d;
    logic [NW-1:0][BITWIDTH-1:0]      sh_wt_q, sh_wt_d;
    logic [N_IN-1:0][BITWIDTH-1:0]    sh_ft_q, sh_ft_d;
    logic                             out_valid_q, out_valid_d;
    logic                             frame_err_q, frame_err_d;

    logic          accept, rel_w, commit, beat_go, beat_w, is_final, cur_full;
    logic [CW-1:0] idx;

    assign in_ready       = (state_q != HOLD) && !rst;
    assign accept         = in_valid && in_ready;
    assign rel_w          = out_valid_q && out_ack;
    assign featuremap     = sh_ft_q;
    assign connect_matrix = sh_wt_q;
    assign out_valid      = out_valid_q;
    assign frame_err      = frame_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        wl_d        = wl_q;
        wt_d        = wt_q;
        ft_d        = ft_q;
        sh_wt_d     = sh_wt_q;
        sh_ft_d     = sh_ft_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        beat_go     = 1'b0;
        beat_w      = 1'b0;
        idx         = '0;
        commit      = 1'b0;
        cur_full    = full_q;
        is_final    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Feature-only frame with no weights to reuse: drop the beat.
                    if (in_feat_only && !wl_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        beat_go  = 1'b1;
                        beat_w   = !in_feat_only;
                        cur_full = !in_feat_only;
                        full_d   = !in_feat_only;
                    end
                end
            end
            LOAD_W: begin
                beat_go = accept;
                beat_w  = 1'b1;
                idx     = cnt_q;
            end
            LOAD_F: begin
                beat_go = accept;
                idx     = cnt_q;
            end
            HOLD: begin
                commit = rel_w;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        is_final = !beat_w && (idx == CW'(N_IN - 1));

        if (beat_go) begin
            if (in_last != is_final) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                cnt_d       = '0;
                // Earlier beats of a full frame already replaced stored weights.
                if (cur_full && state_q != IDLE) wl_d = 1'b0;
            end else begin
                if (beat_w) begin
                    for (int i = 0; i < NW; i++)
                        if (idx == CW'(i)) wt_d[i] = in_data;
                end else begin
                    for (int i = 0; i < N_IN; i++)
                        if (idx == CW'(i)) ft_d[i] = in_data;
                end

                if (beat_w && idx == CW'(NW - 1)) begin
                    state_d = LOAD_F;
                    cnt_d   = '0;
                end else if (is_final) begin
                    cnt_d = '0;
                    if (!out_valid_q || rel_w) commit = 1'b1;
                    else                       state_d = HOLD;
                end else begin
                    state_d = beat_w ? LOAD_W : LOAD_F;
                    cnt_d   = idx + 1'b1;
                end
            end
        end

        // wt_d/ft_d already include the final beat, so the copy sees the whole frame.
        if (commit) begin
            sh_wt_d     = wt_d;
            sh_ft_d     = ft_d;
            out_valid_d = 1'b1;
            state_d     = IDLE;
            if (cur_full) wl_d = 1'b1;
        end else if (rel_w) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            wl_q        <= 1'b0;
            wt_q        <= '0;
            ft_q        <= '0;
            sh_wt_q     <= '0;
            sh_ft_q     <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            wl_q        <= wl_d;
            wt_q        <= wt_d;
            ft_q        <= ft_d;
            sh_wt_q     <= sh_wt_d;
            sh_ft_q     <= sh_ft_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_fc_operand_loader.sv
// Directed + randomized-gap bench for fc_operand_loader with a frame-level queue model
// checked against the DUT every cycle, plus hand-computed literal expectations.
module tb_fc_operand_loader;

    localparam int BW  = 32;
    localparam int NI  = 10;
    localparam int NO  = 10;
    localparam int NW  = NI * NO;
    localparam int TOT = NW + NI;

    logic                          clk;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [BW-1:0]          in_data;
    logic                          in_last;
    logic                          in_feat_only;
    logic signed [NI-1:0][BW-1:0]  featuremap;
    logic signed [NO-1:0][NI-1:0][BW-1:0] connect_matrix;
    logic                          out_valid;
    logic                          out_ack;
    logic                          frame_err;

    fc_operand_loader #(.BITWIDTH(BW), .N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_feat_only(in_feat_only),
        .featuremap(featuremap), .connect_matrix(connect_matrix),
        .out_valid(out_valid), .out_ack(out_ack), .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int m_commits = 0;
    bit rand_ack = 1'b0;
    bit ack_man  = 1'b0;
    logic [BW-1:0] fr [TOT];

    task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- model: frames assembled from accepted beats ----------------
    bit            m_busy, m_full, m_wl, m_pend, m_pfull, m_sv, m_err;
    logic [BW-1:0] m_q [$];
    logic [BW-1:0] m_ww [NW];
    logic [BW-1:0] m_pw [NW];
    logic [BW-1:0] m_pf [NI];
    logic [BW-1:0] m_sw [NW];
    logic [BW-1:0] m_sf [NI];

    task automatic model_step();
        bit rel, done;
        int n, tot;
        if (rst) begin
            m_busy = 0; m_pend = 0; m_sv = 0; m_err = 0; m_wl = 0;
            m_q.delete();
            return;
        end
        rel  = m_sv && out_ack;
        m_err = 0;
        done = 0;
        if (m_pend) begin
            if (rel) begin
                m_sw = m_pw; m_sf = m_pf;
                if (m_pfull) m_wl = 1;
                m_pend = 0; done = 1; m_commits++;
            end
        end else if (in_valid) begin
            if (!m_busy) begin
                if (in_feat_only && !m_wl) m_err = 1;
                else begin
                    m_busy = 1; m_full = !in_feat_only; m_q.delete();
                end
            end
            if (m_busy) begin
                m_q.push_back(in_data);
                n   = m_q.size();
                tot = m_full ? TOT : NI;
                if (in_last != (n == tot)) begin
                    m_err = 1; m_busy = 0;
                    if (m_full && n > 1) m_wl = 0;
                end else if (n == tot) begin
                    m_busy = 0;
                    if (m_full) for (int i = 0; i < NW; i++) m_ww[i] = m_q[i];
                    for (int i = 0; i < NI; i++) m_pf[i] = m_q[tot-NI+i];
                    m_pw = m_ww; m_pfull = m_full;
                    if (!m_sv || rel) begin
                        m_sw = m_pw; m_sf = m_pf;
                        if (m_full) m_wl = 1;
                        done = 1; m_commits++;
                    end else m_pend = 1;
                end
            end
        end
        if (done) m_sv = 1;
        else if (rel) m_sv = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        int bad;
        @(posedge clk);
        #2;
        if (frame_err) err_cnt++;
        chk("out_valid", out_valid, m_sv);
        chk("frame_err", frame_err, m_err);
        chk("in_ready", in_ready, !rst && !m_pend);
        if (m_sv) begin
            bad = -1;
            for (int i = 0; i < NW; i++)
                if (bad < 0 && connect_matrix[i/NI][i%NI] !== m_sw[i]) bad = i;
            for (int i = 0; i < NI; i++)
                if (bad < 0 && featuremap[i] !== m_sf[i]) bad = NW + i;
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                if (bad < NW)
                    $display("FAIL shadow_w[%0d]: got %0h expected %0h", bad,
                             connect_matrix[bad/NI][bad%NI], m_sw[bad]);
                else
                    $display("FAIL shadow_f[%0d]: got %0h expected %0h", bad-NW,
                             featuremap[bad-NW], m_sf[bad-NW]);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        out_ack = rand_ack ? ($urandom_range(0, 3) == 0) : ack_man;
    end

    // ---------------- drivers (always entered at a negedge) ----------------
    task automatic drive_beat(input logic [BW-1:0] d, input bit last, input bit fo, input int gap);
        bit got, ok;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_feat_only = fo;
        ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            got = in_ready;
            @(negedge clk);
            ok = got;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: got no handshake expected accept");
        end
    endtask

    task automatic send_frame(input bit fo, input int nb, input int last_at, input int gmax);
        for (int b = 0; b < nb; b++)
            drive_beat(fr[b], b == last_at, fo, gmax > 0 ? $urandom_range(0, gmax) : 0);
    endtask

    task automatic ack_pulse();
        ack_man = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ack_man = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int e0, c0;
        bit fo;
        rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; in_feat_only = 0; out_ack = 0;
        repeat (3) @(negedge clk);
        chk("ready_in_rst", in_ready, 0);
        chk("valid_in_rst", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        @(negedge clk);

        // feature-only frame with no weights loaded
        e0 = err_cnt;
        fr[0] = 32'd5;
        send_frame(1, 1, -1, 0);
        repeat (3) @(negedge clk);
        chk("fo_err_pulses", err_cnt - e0, 1);
        chk("fo_no_commit", out_valid, 0);
        chk("fo_ready", in_ready, 1);

        // identity weights, features 0..9
        for (int i = 0; i < NW; i++) fr[i] = (i / NI == i % NI) ? 32'd1 : 32'd0;
        for (int i = 0; i < NI; i++) fr[NW+i] = i;
        send_frame(0, TOT, TOT-1, 0);
        chk("id_valid", out_valid, 1);
        chk("id_w33", connect_matrix[3][3], 32'd1);
        chk("id_w34", connect_matrix[3][4], 32'd0);
        chk("id_f7", featuremap[7], 32'd7);

        // feature-only frame 9..0 while shadow is held
        for (int i = 0; i < NI; i++) fr[i] = 9 - i;
        send_frame(1, NI, NI-1, 0);
        chk("hold_ready", in_ready, 0);
        chk("hold_f7_kept", featuremap[7], 32'd7);
        repeat (2) @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        @(negedge clk);
        chk("hold_f0", featuremap[0], 32'd9);
        chk("hold_f9", featuremap[9], 32'd0);
        chk("hold_w22", connect_matrix[2][2], 32'd1);
        chk("hold_valid", out_valid, 1);
        ack_pulse();
        chk("released", out_valid, 0);

        // early in_last on beat 50, then a good frame
        e0 = err_cnt;
        for (int i = 0; i < TOT; i++) fr[i] = 1000 + i;
        send_frame(0, 50, 49, 0);
        @(negedge clk);
        chk("early_last_err", err_cnt - e0, 1);
        chk("early_last_nocommit", out_valid, 0);
        for (int i = 0; i < TOT; i++) fr[i] = 32'hF000_0000 + i;
        send_frame(0, TOT, TOT-1, 0);
        chk("neg_w99", connect_matrix[9][9], 32'hF000_0063);
        chk("neg_f0", featuremap[0], 32'hF000_0064);
        ack_pulse();

        // missing in_last on final beat
        e0 = err_cnt;
        send_frame(0, TOT, -1, 0);
        @(negedge clk);
        chk("no_last_err", err_cnt - e0, 1);
        chk("no_last_nocommit", out_valid, 0);

        // commit, then reset during the next frame
        for (int i = 0; i < TOT; i++) fr[i] = 32'h0BAD_0000 + i;
        send_frame(0, TOT, TOT-1, 0);
        send_frame(0, 59, -1, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = fr[59];
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_f0", featuremap[0], 32'd0);
        chk("rst_w99", connect_matrix[9][9], 32'd0);
        chk("rst_err", frame_err, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < NW; i++) fr[i] = (i / NI == i % NI) ? 32'd1 : 32'd0;
        for (int i = 0; i < NI; i++) fr[NW+i] = 32'd20 + i;
        send_frame(0, TOT, TOT-1, 0);
        chk("rst_reload_w00", connect_matrix[0][0], 32'd1);
        chk("rst_reload_f0", featuremap[0], 32'd20);
        ack_pulse();

        // random gaps and random release over 20 frames
        rand_ack = 1'b1;
        c0 = m_commits;
        for (int f = 0; f < 20; f++) begin
            fo = (f > 0) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < TOT; i++) fr[i] = $urandom;
            send_frame(fo, fo ? NI : TOT, fo ? NI-1 : TOT-1, 2);
        end
        repeat (100) @(negedge clk);
        chk("rand_commits", m_commits - c0, 20);
        rand_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_operand_loader.md
FC_OPERAND_LOADER -- requirements
Module: fc_operand_loader

Interface
REQ-001 Parameter BITWIDTH, default 32: signed width of every weight and feature element.
REQ-002 Parameter N_IN, default 10: feature vector length (matrix columns).
REQ-003 Parameter N_OUT, default 10: output vector length (matrix rows).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  stream beat present.
REQ-007 in_ready  output  1  loader accepts beat; a beat transfers when in_valid && in_ready.
REQ-008 in_data  input  BITWIDTH (signed)  weight or feature element.
REQ-009 in_last  input  1  marks final beat of a frame.
REQ-010 in_feat_only  input  1  sampled on the first beat of a frame; 1 means the frame carries features only and reuses stored weights.
REQ-011 featuremap  output  N_IN x BITWIDTH (signed)  shadow feature vector.
REQ-012 connect_matrix  output  N_OUT x N_IN x BITWIDTH (signed)  shadow weight matrix, indexed [row][col].
REQ-013 out_valid  output  1  shadow operands are complete and stable.
REQ-014 out_ack  input  1  consumer releases the shadow bank; a release occurs when out_valid && out_ack.
REQ-015 frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-016 The block SHALL hold a working bank (written by the stream) and a shadow bank (driving featuremap/connect_matrix); the shadow bank SHALL change only on commit.
REQ-017 The FSM SHALL have the states IDLE, LOAD_W, LOAD_F and HOLD; in_ready SHALL be 1 in IDLE, LOAD_W and LOAD_F, and 0 in HOLD and during rst.
REQ-018 Full frame order: N_OUT*N_IN weights, row-major (row outer, col inner), then N_IN features, for a total of N_OUT*N_IN+N_IN beats.
REQ-019 Feature-only frame order: N_IN features; working weights SHALL be kept unchanged.
REQ-020 In IDLE, the first accepted beat SHALL select LOAD_W (in_feat_only=0) or LOAD_F (in_feat_only=1 and weights_loaded=1), and that beat SHALL be stored at element 0.
REQ-021 If in_feat_only=1 while weights_loaded=0, the beat SHALL be consumed and dropped, frame_err SHALL pulse, and the FSM SHALL stay in IDLE.
REQ-022 A single element counter SHALL advance once per accepted beat, wrap to 0 when moving from LOAD_W to LOAD_F, and clear at frame end.
REQ-023 in_last SHALL be 1 exactly on the final feature beat.
REQ-024 If in_last=1 on any earlier beat, frame_err SHALL pulse, the frame SHALL be discarded, the FSM SHALL return to IDLE, and weights_loaded SHALL clear if weights were partially overwritten.
REQ-025 If in_last=0 on the final beat, frame_err SHALL pulse, the frame SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-026 On a correctly terminated final beat at cycle T, if the shadow bank is free (out_valid=0, or a release occurs at T), the whole working bank SHALL be copied to the shadow bank and out_valid SHALL be 1 at T+1, with the FSM going to IDLE.
REQ-027 Otherwise the FSM SHALL enter HOLD; on the cycle a release occurs, the copy SHALL happen and out_valid SHALL be 1 next cycle (remaining 1 with no gap), with the FSM going to IDLE.
REQ-028 A release with no pending commit SHALL clear out_valid on the next cycle.
REQ-029 weights_loaded SHALL set on the successful commit of a full frame.
REQ-030 Elements SHALL be stored bit-exact with no arithmetic, sign extension or saturation.
REQ-031 Beats with in_valid=0 SHALL not advance state; a stalled stream SHALL wait indefinitely.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, counter=0, both banks=0, out_valid=0, frame_err=0, weights_loaded=0, and in_ready=0.
REQ-033 rst asserted mid-frame or in HOLD SHALL abort the frame with no commit and no frame_err.
REQ-034 After rst deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-035 Full frame of identity weights (1 on the diagonal, else 0) plus features 0..9, with in_last on beat 110 -> the cycle after that beat out_valid=1, connect_matrix[i][i]=1, off-diagonal 0, and featuremap[i]=i.
REQ-036 Commit a frame, hold out_ack=0, and send a feature-only frame with features 9..0 -> in_ready=0 after its last beat; assert out_ack for one cycle -> featuremap reads 9..0 with identity weights kept and out_valid continuously 1.
REQ-037 Feature-only frame immediately after reset -> frame_err pulses once, out_valid stays 0, and in_ready stays 1.
REQ-038 Full frame with in_last on beat 50 -> frame_err pulses, no commit, and the next valid full frame commits correctly.
REQ-039 rst pulsed on beat 60 of a full frame -> all outputs 0 and the next frame loads from element 0.
REQ-040 Random in_valid gaps and random out_ack over 20 frames -> the scoreboard matches every committed bank with no lost or duplicated beats.
